// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with oversampled mid-bit sampling
// Start glitches are rejected at the start-bit midpoint; a low stop bit parks the FSM in BREAK until the line idles.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 baud_clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] Data,
  output logic                 valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q;
  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_error_q;
  logic                 busy_q;

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
      // busy_q tracks the next state so it matches state_q on every cycle
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s_q;
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            data_q <= shift_q;
            if (rx_s_q) begin
              valid_q <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Data        = data_q;
  assign valid       = valid_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
// Drives 16x-oversampled 8N1 frames on the falling clock edge and logs output pulses with edge numbers.
module tb_uart_receiver;

  logic       baud_clk;
  logic       reset;
  logic       rx;
  logic [7:0] Data;
  logic       valid;
  logic       frame_error;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  int         valid_cyc[$];
  logic [7:0] valid_data[$];
  int         fe_cyc[$];

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .baud_clk   (baud_clk),
    .reset      (reset),
    .rx         (rx),
    .Data       (Data),
    .valid      (valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  initial begin
    baud_clk = 1'b0;
    forever #5 baud_clk = ~baud_clk;
  end

  always @(posedge baud_clk) cyc <= cyc + 1;

  // Pulse log: cyc at a falling edge is the number of the rising edge just taken
  always @(negedge baud_clk) begin
    if (valid) begin
      valid_cyc.push_back(cyc);
      valid_data.push_back(Data);
    end
    if (frame_error) fe_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic clear_log();
    valid_cyc.delete();
    valid_data.delete();
    fe_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, output int first_edge);
    first_edge = cyc + 1;
    rx = 1'b0;
    cycles(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(16);
    end
    rx = stop;
    cycles(16);
  endtask

  initial begin
    int t0, t1, t2, t3;
    logic [7:0] fe_byte;
    reset = 1'b1;
    rx    = 1'b1;
    cycles(3);
    chk("reset_data", Data, 8'h00);
    chk("reset_valid", valid, 1'b0);
    chk("reset_frame_error", frame_error, 1'b0);
    chk("reset_busy", busy, 1'b0);
    reset = 1'b0;
    cycles(20);

    // Single good frame, latency from first sampled falling edge
    clear_log();
    send_byte(8'hA5, 1'b1, t0);
    cycles(10);
    chk("a5_valid_count", valid_cyc.size(), 1);
    if (valid_cyc.size() > 0) begin
      chk("a5_latency", valid_cyc[0] - t0, 154);
      chk("a5_pulse_data", valid_data[0], 8'hA5);
    end
    chk("a5_data_hold", Data, 8'hA5);
    chk("a5_no_frame_error", fe_cyc.size(), 0);
    chk("a5_busy_idle", busy, 1'b0);

    // Back-to-back frames with no idle gap
    clear_log();
    send_byte(8'h00, 1'b1, t1);
    send_byte(8'hFF, 1'b1, t2);
    send_byte(8'h3C, 1'b1, t3);
    rx = 1'b1;
    cycles(10);
    chk("b2b_valid_count", valid_cyc.size(), 3);
    if (valid_cyc.size() == 3) begin
      chk("b2b_first_latency", valid_cyc[0] - t1, 154);
      chk("b2b_gap_1", valid_cyc[1] - valid_cyc[0], 160);
      chk("b2b_gap_2", valid_cyc[2] - valid_cyc[1], 160);
      chk("b2b_data_0", valid_data[0], 8'h00);
      chk("b2b_data_1", valid_data[1], 8'hFF);
      chk("b2b_data_2", valid_data[2], 8'h3C);
    end
    chk("b2b_no_frame_error", fe_cyc.size(), 0);

    // Four-cycle glitch must be rejected at the start-bit midpoint
    clear_log();
    rx = 1'b0;
    cycles(4);
    chk("glitch_busy_rises", busy, 1'b1);
    rx = 1'b1;
    cycles(8);
    chk("glitch_busy_dropped", busy, 1'b0);
    cycles(20);
    chk("glitch_no_valid", valid_cyc.size(), 0);
    chk("glitch_no_frame_error", fe_cyc.size(), 0);
    chk("glitch_data_kept", Data, 8'h3C);

    // Low stop bit followed by a held break
    clear_log();
    send_byte(8'h55, 1'b0, t0);
    cycles(40);
    chk("break_fe_count", fe_cyc.size(), 1);
    if (fe_cyc.size() > 0) chk("break_fe_latency", fe_cyc[0] - t0, 154);
    chk("break_no_valid", valid_cyc.size(), 0);
    chk("break_data", Data, 8'h55);
    chk("break_busy_held", busy, 1'b1);
    rx = 1'b1;
    cycles(2);
    chk("break_busy_before_release", busy, 1'b1);
    cycles(1);
    chk("break_busy_after_release", busy, 1'b0);
    cycles(30);
    chk("break_no_retrigger", valid_cyc.size() + fe_cyc.size(), 1);

    // Reset during data bit 3 of frame 0xFE, then a clean 0x81
    clear_log();
    fe_byte = 8'hFE;
    rx = 1'b0;
    cycles(16);
    for (int i = 0; i < 3; i++) begin
      rx = fe_byte[i];
      cycles(16);
    end
    rx = fe_byte[3];
    cycles(8);
    chk("midframe_busy", busy, 1'b1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    chk("midreset_data", Data, 8'h00);
    chk("midreset_valid", valid, 1'b0);
    chk("midreset_frame_error", frame_error, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    cycles(8);
    for (int i = 4; i < 8; i++) begin
      rx = fe_byte[i];
      cycles(16);
    end
    rx = 1'b1;
    cycles(36);
    chk("midreset_no_pulses", valid_cyc.size() + fe_cyc.size(), 0);
    chk("midreset_idle", busy, 1'b0);
    send_byte(8'h81, 1'b1, t0);
    cycles(10);
    chk("post_reset_valid_count", valid_cyc.size(), 1);
    if (valid_cyc.size() > 0) begin
      chk("post_reset_latency", valid_cyc[0] - t0, 154);
      chk("post_reset_pulse_data", valid_data[0], 8'h81);
    end
    chk("post_reset_data", Data, 8'h81);
    chk("post_reset_no_frame_error", fe_cyc.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
